// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the host-side processor sequencer.
//   - processor status pin encodings (RUN / LOAD / HOLD)
//   - sequencer FSM state type
//   - default data-memory address/data widths
package proc_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // Processor mode pins. HOLD makes the core drop dm_en, so no DM write can occur.
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_LOAD = 2'b10;
  localparam logic [1:0] ST_HOLD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_RADDR = 3'd3,
    S_RWAIT = 3'd4,
    S_ROUT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/proc_host_ctrl_if.sv
// proc_host_ctrl_if: pin bundle between the host sequencer and the processor.
//   status       host -> core  processor mode (01 RUN, 10 LOAD, 11 HOLD)
//   data_in      host -> core  byte written to DM in LOAD
//   data_addr_in host -> core  DM address for LOAD / READ
//   end_process  core -> host  program-complete flag
//   dm_out       core -> host  DM read data
// Modports: master = host sequencer side, slave = processor side.
interface proc_host_ctrl_if
  import proc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [1:0]        status;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] data_addr_in;
  logic              end_process;
  logic [DATA_W-1:0] dm_out;

  modport master (
    output status,
    output data_in,
    output data_addr_in,
    input  end_process,
    input  dm_out
  );

  modport slave (
    input  status,
    input  data_in,
    input  data_addr_in,
    output end_process,
    output dm_out
  );

endinterface

// File: rtl/hostctl_rdpipe.sv
// hostctl_rdpipe: RD_LAT-deep valid shift register. A launch pulse in the cycle
// the read address is on the pins re-emerges as strobe_o exactly RD_LAT cycles
// later, which is the cycle dm_out carries the addressed byte.
//   clk, rst   clock / synchronous active-high reset
//   launch_i   read address presented this cycle
//   strobe_o   dm_out valid this cycle
module hostctl_rdpipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic launch_i,
  output logic strobe_o
);

  logic [RD_LAT-1:0] pipe_q;
  logic [RD_LAT-1:0] pipe_d;

  // Next-state of the shift register: launch enters at bit 0.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = launch_i;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Shift register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= {RD_LAT{1'b0}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign strobe_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/proc_host_ctrl.sv
// proc_host_ctrl: host sequencer in front of the processor.
// Loads a byte stream into DM (status LOAD), releases the core (RUN), waits for
// a rising end_process (or watchdog expiry), then streams a DM window back out.
//   clk, rst                     clock / synchronous active-high reset
//   start_i, ld_len_i,
//   rd_base_i, rd_len_i          job request, sampled on an accepted start
//   in_valid_i/in_data_i/in_ready_o     load byte stream
//   out_valid_o/out_data_o/out_ready_i  readback byte stream
//   busy_o, done_o, err_o        job status (err is a sticky timeout flag)
//   proc_if                      processor pins (master side)
module proc_host_ctrl
  import proc_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RD_LAT      = 2,
  parameter int RUN_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] ld_len_i,
  input  logic [ADDR_W-1:0] rd_base_i,
  input  logic [ADDR_W-1:0] rd_len_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  proc_host_ctrl_if.master  proc_if
);

  localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]       TO_LAST = RUN_TIMEOUT - 1;

  state_e            state_q;
  logic [ADDR_W-1:0] ld_len_q;
  logic [ADDR_W-1:0] rd_len_q;
  logic [ADDR_W-1:0] ld_cnt_q;   // load count, doubles as the load address (both start at 0)
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic [31:0]       run_cnt_q;
  logic              end_prev_q;
  logic [1:0]        status_q;
  logic [DATA_W-1:0] data_in_q;
  logic [ADDR_W-1:0] data_addr_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic rd_launch_s;
  logic rd_strobe_s;
  logic end_rise_s;
  logic in_fire_s;
  logic out_fire_s;
  logic wd_hit_s;

  assign rd_launch_s = (state_q == S_RADDR);
  // Only a fresh rising edge ends RUN; a level left high by a previous job is ignored.
  assign end_rise_s  = proc_if.end_process & ~end_prev_q;
  assign in_fire_s   = in_valid_i & in_ready_q;
  assign out_fire_s  = out_valid_q & out_ready_i;
  assign wd_hit_s    = (RUN_TIMEOUT != 0) && (run_cnt_q == TO_LAST);

  hostctl_rdpipe #(.RD_LAT(RD_LAT)) u_rdpipe (
    .clk      (clk),
    .rst      (rst),
    .launch_i (rd_launch_s),
    .strobe_o (rd_strobe_s)
  );

  // Sequencer FSM with all counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ld_len_q    <= ZERO_A;
      rd_len_q    <= ZERO_A;
      ld_cnt_q    <= ZERO_A;
      rd_addr_q   <= ZERO_A;
      rd_cnt_q    <= ZERO_A;
      run_cnt_q   <= 32'd0;
      end_prev_q  <= 1'b0;
      status_q    <= ST_HOLD;
      data_in_q   <= {DATA_W{1'b0}};
      data_addr_q <= ZERO_A;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      end_prev_q <= proc_if.end_process;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          status_q <= ST_HOLD;
          if (start_i) begin
            ld_len_q  <= ld_len_i;
            rd_len_q  <= rd_len_i;
            rd_addr_q <= rd_base_i;
            ld_cnt_q  <= ZERO_A;
            rd_cnt_q  <= ZERO_A;
            run_cnt_q <= 32'd0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            if (ld_len_i != ZERO_A) begin
              state_q    <= S_LOAD;
              in_ready_q <= 1'b1;
            end else begin
              state_q  <= S_RUN;
              status_q <= ST_RUN;
            end
          end
        end
        S_LOAD: begin
          if (in_fire_s) begin
            // Issue the accepted byte as a DM write on the next cycle.
            status_q    <= ST_LOAD;
            data_in_q   <= in_data_i;
            data_addr_q <= ld_cnt_q;
            ld_cnt_q    <= ld_cnt_q + ONE_A;
            if (ld_cnt_q == ld_len_q - ONE_A) begin
              in_ready_q <= 1'b0;
            end
          end else if (!in_ready_q) begin
            // in_ready is low only during the final-issue cycle.
            state_q  <= S_RUN;
            status_q <= ST_RUN;
          end else begin
            status_q <= ST_HOLD;
          end
        end
        S_RUN: begin
          run_cnt_q <= run_cnt_q + 32'd1;
          if (end_rise_s) begin
            status_q <= ST_HOLD;
            if (rd_len_q != ZERO_A) begin
              state_q     <= S_RADDR;
              data_addr_q <= rd_addr_q;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else if (wd_hit_s) begin
            status_q <= ST_HOLD;
            err_q    <= 1'b1;
            state_q  <= S_DONE;
            done_q   <= 1'b1;
          end else begin
            status_q <= ST_RUN;
          end
        end
        S_RADDR: begin
          status_q <= ST_HOLD;
          state_q  <= S_RWAIT;
        end
        S_RWAIT: begin
          status_q <= ST_HOLD;
          if (rd_strobe_s) begin
            out_data_q  <= proc_if.dm_out;
            out_valid_q <= 1'b1;
            state_q     <= S_ROUT;
          end
        end
        S_ROUT: begin
          status_q <= ST_HOLD;
          if (out_fire_s) begin
            out_valid_q <= 1'b0;
            rd_addr_q   <= rd_addr_q + ONE_A;
            rd_cnt_q    <= rd_cnt_q + ONE_A;
            if (rd_cnt_q == rd_len_q - ONE_A) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_RADDR;
              data_addr_q <= rd_addr_q + ONE_A;
            end
          end
        end
        S_DONE: begin
          // start is deliberately not looked at here.
          status_q <= ST_HOLD;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          status_q    <= ST_HOLD;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o           = in_ready_q;
  assign out_valid_o          = out_valid_q;
  assign out_data_o           = out_data_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign err_o                = err_q;
  assign proc_if.status       = status_q;
  assign proc_if.data_in      = data_in_q;
  assign proc_if.data_addr_in = data_addr_q;

endmodule

// File: tb/tb_proc_host_ctrl.sv
// tb_proc_host_ctrl: self-checking bench for proc_host_ctrl.
// A behavioural processor/DM model answers the processor pins; a reference
// memory (written from the load streams) predicts every readback byte.
module tb_proc_host_ctrl;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main DUT (watchdog disabled)
  logic        start, in_valid, in_ready, out_valid, out_ready, busy, done, err;
  logic [15:0] ld_len, rd_base, rd_len;
  logic [7:0]  in_data, out_data;
  proc_host_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  proc_host_ctrl #(.ADDR_W(16), .DATA_W(8), .RD_LAT(2), .RUN_TIMEOUT(0)) dut (
    .clk(clk), .rst(rst), .start_i(start), .ld_len_i(ld_len), .rd_base_i(rd_base),
    .rd_len_i(rd_len), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done), .err_o(err), .proc_if(bus)
  );

  // Watchdog DUT (RUN_TIMEOUT=8), end_process never rises
  logic        wd_start, wd_in_ready, wd_out_valid, wd_busy, wd_done, wd_err;
  logic [15:0] wd_ld_len, wd_rd_base, wd_rd_len;
  logic [7:0]  wd_out_data;
  proc_host_ctrl_if #(.ADDR_W(16), .DATA_W(8)) wd_bus ();
  assign wd_bus.end_process = 1'b0;
  assign wd_bus.dm_out      = 8'h00;

  proc_host_ctrl #(.ADDR_W(16), .DATA_W(8), .RD_LAT(2), .RUN_TIMEOUT(8)) dut_wd (
    .clk(clk), .rst(rst), .start_i(wd_start), .ld_len_i(wd_ld_len), .rd_base_i(wd_rd_base),
    .rd_len_i(wd_rd_len), .in_valid_i(1'b0), .in_data_i(8'h00), .in_ready_o(wd_in_ready),
    .out_valid_o(wd_out_valid), .out_data_o(wd_out_data), .out_ready_i(1'b1),
    .busy_o(wd_busy), .done_o(wd_done), .err_o(wd_err), .proc_if(wd_bus)
  );

  // Processor + DM model: writes in LOAD, registered address then sync read.
  logic [7:0]  dm_mem [0:65535];
  bit          dm_wr  [0:65535];
  logic [15:0] addr_r;
  int          wr_events = 0;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] dm_peek(input logic [15:0] a);
    return dm_wr[a] ? dm_mem[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (bus.status == ST_LOAD) begin
      dm_mem[bus.data_addr_in] <= bus.data_in;
      dm_wr[bus.data_addr_in]  <= 1'b1;
      wr_events                <= wr_events + 1;
    end
    addr_r     <= bus.data_addr_in;
    bus.dm_out <= dm_peek(addr_r);
  end

  // Reference memory: what DM should hold after all loads so far.
  logic [7:0] ref_mem [int];
  function automatic logic [7:0] ref_byte(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full job on the main DUT with checks against the reference model.
  //   gap: 0 back-to-back, 1 one byte every 3 cycles, 2 random
  //   stall: 0 always ready, 1 random, 2 ready low 5 cycles per byte
  task automatic run_job(input int n_ld, input int gap, input logic [15:0] rdb,
                         input logic [15:0] rdl, input int end_dly, input bit end_pre,
                         input int stall);
    logic [7:0]  bytes[$];
    logic [7:0]  got[$];
    logic [7:0]  last_data;
    logic [15:0] last_addr;
    int idx = 0, run_seen = 0, done_seen = 0, cyc = 0, wr0, vcyc = 0;
    bit pend = 1'b0;
    for (int i = 0; i < n_ld; i++) bytes.push_back(8'($urandom));
    wr0 = wr_events;
    bus.end_process = end_pre;
    start = 1'b1; ld_len = 16'(n_ld); rd_base = rdb; rd_len = rdl;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    while (done_seen == 0 && cyc < 3000) begin
      // stray start and changed parameters mid-job must be ignored
      start = (cyc == 3);
      if (cyc == 3) begin
        ld_len = 16'($urandom); rd_base = 16'($urandom); rd_len = 16'($urandom);
      end
      if (idx < n_ld) begin
        case (gap)
          0:       in_valid = 1'b1;
          1:       in_valid = (cyc % 3 == 0);
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        in_data = bytes[idx];
        if (in_valid && in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      if (bus.status == ST_RUN) begin
        run_seen++;
        if (end_pre && run_seen == 1) bus.end_process = 1'b0;
        if (run_seen == end_dly) bus.end_process = 1'b1;
      end
      if (out_valid) begin
        if (pend) begin
          check("rout_data_hold", out_data, last_data);
          check("rout_addr_hold", bus.data_addr_in, last_addr);
        end
        case (stall)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = (vcyc >= 5);
        endcase
        if (out_ready) begin
          got.push_back(out_data);
          pend = 1'b0;
          vcyc = 0;
        end else begin
          pend = 1'b1;
          last_data = out_data;
          last_addr = bus.data_addr_in;
          vcyc++;
        end
      end else begin
        pend = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        done_seen++;
        check("busy_in_done", busy, 1);
      end
      tick();
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    check("job_done", done_seen, 1);
    check("ld_bytes_taken", idx, n_ld);
    check("ld_writes", wr_events - wr0, n_ld);
    check("run_cycles", run_seen, end_dly);
    check("err_clear", err, 0);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    for (int i = 0; i < n_ld; i++) ref_mem[i] = bytes[i];
    for (int i = 0; i < n_ld; i++) check("dm_content", dm_peek(16'(i)), ref_byte(16'(i)));
    check("rd_count", got.size(), int'(rdl));
    for (int i = 0; i < got.size() && i < int'(rdl); i++)
      check("rd_data", got[i], ref_byte(rdb + 16'(i)));
  endtask

  initial begin
    int wd_run, wd_cyc;
    bit wd_ov;
    rst = 1'b1; start = 1'b0; ld_len = 16'd0; rd_base = 16'd0; rd_len = 16'd0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; bus.end_process = 1'b0;
    wd_start = 1'b0; wd_ld_len = 16'd0; wd_rd_base = 16'd0; wd_rd_len = 16'd2;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset values
    check("rst_status", bus.status, ST_HOLD);
    check("rst_data_in", bus.data_in, 0);
    check("rst_addr", bus.data_addr_in, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // Directed: 3 bytes back-to-back
    start = 1'b1; ld_len = 16'd3; rd_base = 16'd0; rd_len = 16'd0;
    tick();
    start = 1'b0;
    check("t1_in_ready", in_ready, 1);
    check("t1_hold", bus.status, ST_HOLD);
    in_valid = 1'b1; in_data = 8'hA1;
    tick();
    check("t1_st0", bus.status, ST_LOAD); check("t1_d0", bus.data_in, 8'hA1); check("t1_a0", bus.data_addr_in, 0);
    in_data = 8'hB2;
    tick();
    check("t1_st1", bus.status, ST_LOAD); check("t1_d1", bus.data_in, 8'hB2); check("t1_a1", bus.data_addr_in, 1);
    in_data = 8'hC3;
    tick();
    check("t1_st2", bus.status, ST_LOAD); check("t1_d2", bus.data_in, 8'hC3); check("t1_a2", bus.data_addr_in, 2);
    check("t1_rdy_final", in_ready, 0);
    in_valid = 1'b0;
    tick();
    check("t1_run", bus.status, ST_RUN);
    bus.end_process = 1'b1;
    tick();
    check("t1_done", done, 1);
    check("t1_done_hold", bus.status, ST_HOLD);
    tick();
    check("t1_idle_done", done, 0);
    check("t1_idle_busy", busy, 0);
    ref_mem[0] = 8'hA1; ref_mem[1] = 8'hB2; ref_mem[2] = 8'hC3;
    for (int i = 0; i < 3; i++) check("t1_dm", dm_peek(16'(i)), ref_byte(16'(i)));

    // Gapped load, end_process still high from the previous job
    run_job(3, 1, 16'h0000, 16'd3, 4, 1'b1, 0);
    // Held level, falls, rises 10 cycles later; readback DM[0010], DM[0011]
    run_job(18, 2, 16'h0010, 16'd2, 11, 1'b1, 1);
    // Consumer stalls 5 cycles per byte
    run_job(5, 0, 16'h0001, 16'd3, 3, 1'b0, 2);
    // Random jobs
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(0, 20), 2, 16'($urandom), 16'($urandom_range(0, 4)),
              $urandom_range(2, 12), 1'($urandom_range(0, 1)), 1);
    // Address wrap on readback
    run_job(0, 0, 16'hFFFF, 16'd2, 2, 1'b0, 1);

    // Watchdog: 8 RUN cycles, err, done, no readback; next start clears err
    for (int k = 0; k < 2; k++) begin
      wd_start = 1'b1;
      tick();
      wd_start = 1'b0;
      check("wd_err_cleared", wd_err, 0);
      wd_run = 0; wd_cyc = 0; wd_ov = 1'b0;
      while (!wd_done && wd_cyc < 100) begin
        if (wd_bus.status == ST_RUN) wd_run++;
        if (wd_out_valid) wd_ov = 1'b1;
        tick();
        wd_cyc++;
      end
      check("wd_done", wd_done, 1);
      check("wd_run_cycles", wd_run, 8);
      check("wd_err", wd_err, 1);
      check("wd_no_readback", wd_ov, 0);
      tick();
      check("wd_err_sticky", wd_err, 1);
      check("wd_idle", wd_busy, 0);
    end

    // Reset mid-LOAD
    bus.end_process = 1'b0;
    start = 1'b1; ld_len = 16'd10; rd_len = 16'd0;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("mrst_status", bus.status, ST_HOLD);
    check("mrst_busy", busy, 0);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_no_done", done, 0);
      check("mrst_idle_status", bus.status, ST_HOLD);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
